// File: rtl/freesrp_pkg.sv
// Shared definitions for the FreeSRP datapath sequencer: state codes, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package freesrp_pkg;

  // Debug-visible state encoding; kept as plain constants so the register
  // values are stable for firmware that decodes the state port.
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_RESET  = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_IDLE   = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_FLUSH  = 3'd4;

  // Default sequencing thresholds and FIFO count width.
  localparam int RST_CYCLES_DEF      = 16;
  localparam int TX_START_THRESH_DEF = 256;
  localparam int FLUSH_TIMEOUT_DEF   = 4095;
  localparam int CW_DEF              = 12;

  // Registered control outputs, grouped so they are updated together.
  typedef struct packed {
    logic fifo_rst;
    logic rx_enable;
    logic tx_enable;
    logic busy;
  } ctrl_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Only IDLE and RUN count as "not busy" to the processor.
  function automatic logic state_is_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_RUN));
  endfunction

endpackage

// File: rtl/datapath_sequencer_rise_edge_det.sv
// Rising-edge detector: registered copy of a level, pulse = level AND NOT copy.
// Latency: pulse is combinational, high for the one cycle after the level rises.
// Backpressure: none; the pulse is consumed on the next clock edge or lost.
module rise_edge_det (
  input  logic clk,
  input  logic reset_b,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember last cycle's level so a new high can be told from a held high.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/datapath_sequencer.sv
// Sequences FIFO reset, settle, and transceiver RX/TX enables for the datapath.
// Latency: every output is registered and moves on the same edge as the state.
// Backpressure: none; commands are levels/edges, TX start waits on FIFO fill.
module datapath_sequencer
  import freesrp_pkg::*;
#(
  parameter int RST_CYCLES      = RST_CYCLES_DEF,
  parameter int TX_START_THRESH = TX_START_THRESH_DEF,
  parameter int FLUSH_TIMEOUT   = FLUSH_TIMEOUT_DEF,
  parameter int CW              = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          cmd_enable,
  input  logic          cmd_flush,
  input  logic          cmd_reset,
  input  logic [CW-1:0] tx_rd_count,
  input  logic          tx_empty,
  input  logic          rx_empty,
  output logic          fifo_rst,
  output logic          rx_enable,
  output logic          tx_enable,
  output logic          busy,
  output logic          underrun,
  output logic          error,
  output logic [2:0]    state
);

  // One shared counter sized for the longer of the reset and flush windows.
  localparam int CNT_W = $clog2(max_int(RST_CYCLES, FLUSH_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CW-1:0]    TX_THRESH  = CW'(TX_START_THRESH);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tx_nxt;
  logic             underrun_nxt;
  logic             error_nxt;
  logic             flush_rise;
  logic             reset_rise;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_nxt;

  rise_edge_det u_flush_edge (
    .clk     (clk),
    .reset_b (reset_b),
    .din     (cmd_flush),
    .rise    (flush_rise)
  );

  rise_edge_det u_reset_edge (
    .clk     (clk),
    .reset_b (reset_b),
    .din     (cmd_reset),
    .rise    (reset_rise)
  );

  // Saturating increment: the counter never wraps back into a valid window.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  // Next-state decision; a datapath reset request outranks everything else.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    tx_nxt       = ctrl_q.tx_enable;
    underrun_nxt = underrun;
    error_nxt    = error;

    if (reset_rise) begin
      state_nxt    = ST_RESET;
      cnt_nxt      = '0;
      tx_nxt       = 1'b0;
      underrun_nxt = 1'b0;
      error_nxt    = 1'b0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          tx_nxt = 1'b0;
          if (cnt_q == RST_LAST) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        ST_SETTLE: begin
          tx_nxt = 1'b0;
          if (cnt_q == RST_LAST) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        ST_IDLE: begin
          // Only here is cmd_enable looked at, so a request held through
          // reset/settle takes effect once the FIFOs are ready.
          tx_nxt = 1'b0;
          if (cmd_enable) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end

        ST_RUN: begin
          if (flush_rise) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = '0;
            tx_nxt    = 1'b0;
          end else if (!cmd_enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tx_nxt    = 1'b0;
          end else if (ctrl_q.tx_enable && tx_empty) begin
            // FIFO starved the transmitter: stop, flag it, wait for refill.
            tx_nxt       = 1'b0;
            underrun_nxt = 1'b1;
          end else if (!ctrl_q.tx_enable && (tx_rd_count > TX_THRESH)) begin
            tx_nxt = 1'b1;
          end
        end

        ST_FLUSH: begin
          // Drain wins over timeout when both land in the same cycle.
          tx_nxt = 1'b0;
          if (rx_empty && tx_empty) begin
            state_nxt = ST_RESET;
            cnt_nxt   = '0;
          end else if (cnt_q == FLUSH_LAST) begin
            state_nxt = ST_RESET;
            cnt_nxt   = '0;
            error_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        default: begin
          state_nxt = ST_RESET;
          cnt_nxt   = '0;
          tx_nxt    = 1'b0;
        end
      endcase
    end
  end

  // Derive the registered control outputs from the state being entered.
  always_comb begin
    ctrl_nxt           = '0;
    ctrl_nxt.fifo_rst  = (state_nxt == ST_RESET);
    ctrl_nxt.rx_enable = (state_nxt == ST_RUN);
    ctrl_nxt.tx_enable = tx_nxt && (state_nxt == ST_RUN);
    ctrl_nxt.busy      = state_is_busy(state_nxt);
  end

  // State, counter, sticky flags and controls all advance on one edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      ctrl_q   <= '{fifo_rst: 1'b1, rx_enable: 1'b0, tx_enable: 1'b0, busy: 1'b1};
      underrun <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      ctrl_q   <= ctrl_nxt;
      underrun <= underrun_nxt;
      error    <= error_nxt;
    end
  end

  assign fifo_rst  = ctrl_q.fifo_rst;
  assign rx_enable = ctrl_q.rx_enable;
  assign tx_enable = ctrl_q.tx_enable;
  assign busy      = ctrl_q.busy;
  assign state     = state_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed sequence plus random RUN traffic.
// Latency: inputs driven on falling edge, outputs sampled on falling edge.
// Backpressure: n/a.
module tb_datapath_sequencer;
  import freesrp_pkg::*;

  localparam int RC  = 16;
  localparam int THR = 256;
  localparam int FTO = 4095;

  logic        clk;
  logic        reset_b;
  logic        cmd_enable;
  logic        cmd_flush;
  logic        cmd_reset;
  logic [11:0] tx_rd_count;
  logic        tx_empty;
  logic        rx_empty;
  logic        fifo_rst;
  logic        rx_enable;
  logic        tx_enable;
  logic        busy;
  logic        underrun;
  logic        error;
  logic [2:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  datapath_sequencer dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .cmd_enable  (cmd_enable),
    .cmd_flush   (cmd_flush),
    .cmd_reset   (cmd_reset),
    .tx_rd_count (tx_rd_count),
    .tx_empty    (tx_empty),
    .rx_empty    (rx_empty),
    .fifo_rst    (fifo_rst),
    .rx_enable   (rx_enable),
    .tx_enable   (tx_enable),
    .busy        (busy),
    .underrun    (underrun),
    .error       (error),
    .state       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference for RUN/IDLE behaviour: run flag, tx flag, sticky underrun.
  bit m_run, m_tx, m_ur;

  initial begin
    reset_b     = 1'b0;
    cmd_enable  = 1'b0;
    cmd_flush   = 1'b0;
    cmd_reset   = 1'b0;
    tx_rd_count = 12'd0;
    tx_empty    = 1'b0;
    rx_empty    = 1'b0;
    repeat (3) step();

    // Reset values while reset_b is held low.
    chk("rst_state", 32'(state), 32'(ST_RESET));
    chk("rst_fifo_rst", 32'(fifo_rst), 32'd1);
    chk("rst_rx_en", 32'(rx_enable), 32'd0);
    chk("rst_tx_en", 32'(tx_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Release reset with cmd_enable already high: it must wait for IDLE.
    cmd_enable  = 1'b1;
    tx_rd_count = 12'd256;
    reset_b     = 1'b1;
    for (int i = 0; i < 2 * RC; i++) begin
      chk("seq_fifo_rst", 32'(fifo_rst), (i < RC) ? 32'd1 : 32'd0);
      chk("seq_state", 32'(state), (i < RC) ? 32'(ST_RESET) : 32'(ST_SETTLE));
      chk("seq_busy", 32'(busy), 32'd1);
      chk("seq_rx_en", 32'(rx_enable), 32'd0);
      step();
    end
    chk("idle_state", 32'(state), 32'(ST_IDLE));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rx_en", 32'(rx_enable), 32'd0);

    // Enter RUN; count equal to threshold must not start TX.
    step();
    chk("run_state", 32'(state), 32'(ST_RUN));
    chk("run_rx_en", 32'(rx_enable), 32'd1);
    chk("run_tx_thr_eq", 32'(tx_enable), 32'd0);
    step();
    chk("run_tx_thr_eq2", 32'(tx_enable), 32'd0);
    tx_rd_count = 12'd257;
    step();
    chk("run_tx_start", 32'(tx_enable), 32'd1);
    chk("run_underrun0", 32'(underrun), 32'd0);

    // One-cycle underrun, then re-arm with a fuller FIFO.
    tx_empty = 1'b1;
    step();
    chk("ur_tx_drop", 32'(tx_enable), 32'd0);
    chk("ur_set", 32'(underrun), 32'd1);
    tx_empty    = 1'b0;
    tx_rd_count = 12'd300;
    step();
    chk("ur_tx_rearm", 32'(tx_enable), 32'd1);
    chk("ur_sticky", 32'(underrun), 32'd1);

    // Flush that drains after 10 cycles.
    cmd_enable = 1'b0;
    cmd_flush  = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      chk("fl_state", 32'(state), 32'(ST_FLUSH));
      chk("fl_tx_en", 32'(tx_enable), 32'd0);
      chk("fl_rx_en", 32'(rx_enable), 32'd0);
      chk("fl_busy", 32'(busy), 32'd1);
      if (k == 10) begin
        rx_empty = 1'b1;
        tx_empty = 1'b1;
      end
      step();
    end
    chk("fl_exit_state", 32'(state), 32'(ST_RESET));
    chk("fl_exit_fifo_rst", 32'(fifo_rst), 32'd1);
    repeat (RC) step();
    chk("fl_settle", 32'(state), 32'(ST_SETTLE));
    repeat (RC) step();
    chk("fl_idle", 32'(state), 32'(ST_IDLE));
    chk("fl_error", 32'(error), 32'd0);

    // A flush edge outside RUN is ignored.
    cmd_flush = 1'b0;
    step();
    cmd_flush = 1'b1;
    step();
    chk("fl_ign_idle", 32'(state), 32'(ST_IDLE));
    step();
    chk("fl_ign_idle2", 32'(state), 32'(ST_IDLE));

    // Flush that never drains: timeout after FTO cycles.
    cmd_flush   = 1'b0;
    cmd_enable  = 1'b1;
    tx_rd_count = 12'd0;
    step();
    chk("to_run", 32'(state), 32'(ST_RUN));
    cmd_flush  = 1'b1;
    cmd_enable = 1'b0;
    rx_empty   = 1'b0;
    tx_empty   = 1'b1;
    step();
    chk("to_flush", 32'(state), 32'(ST_FLUSH));
    repeat (FTO - 1) step();
    chk("to_last_cycle", 32'(state), 32'(ST_FLUSH));
    chk("to_err_before", 32'(error), 32'd0);
    step();
    chk("to_reset", 32'(state), 32'(ST_RESET));
    chk("to_err_set", 32'(error), 32'd1);
    repeat (2 * RC) step();
    chk("to_idle", 32'(state), 32'(ST_IDLE));
    chk("to_err_sticky", 32'(error), 32'd1);
    cmd_reset = 1'b1;
    step();
    chk("to_cmdrst_state", 32'(state), 32'(ST_RESET));
    chk("to_cmdrst_err", 32'(error), 32'd0);
    cmd_reset = 1'b0;
    repeat (2 * RC) step();
    chk("to_idle2", 32'(state), 32'(ST_IDLE));

    // Simultaneous reset and flush edges in RUN: reset wins, FLUSH never seen.
    cmd_flush  = 1'b0;
    cmd_enable = 1'b1;
    step();
    chk("pri_run", 32'(state), 32'(ST_RUN));
    cmd_reset = 1'b1;
    cmd_flush = 1'b1;
    step();
    chk("pri_reset", 32'(state), 32'(ST_RESET));
    chk("pri_underrun_clr", 32'(underrun), 32'd0);
    for (int k = 0; k < 2 * RC + 8; k++) begin
      chk("pri_no_flush", 32'(state != ST_FLUSH), 32'd1);
      step();
    end
    chk("pri_back_run", 32'(state), 32'(ST_RUN));
    cmd_reset = 1'b0;
    cmd_flush = 1'b0;

    // Random RUN/IDLE traffic against the behavioural rules.
    m_run = 1'b1;
    m_tx  = 1'b0;
    m_ur  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bit en, emp;
      int cnt;
      en  = ($urandom_range(0, 15) != 0);
      emp = ($urandom_range(0, 7) == 0);
      cnt = $urandom_range(THR - 6, THR + 6);
      cmd_enable  = en;
      tx_empty    = emp;
      tx_rd_count = 12'(cnt);
      step();
      if (!m_run) begin
        m_run = en;
      end else if (!en) begin
        m_run = 1'b0;
        m_tx  = 1'b0;
      end else if (m_tx && emp) begin
        m_tx = 1'b0;
        m_ur = 1'b1;
      end else if (!m_tx && cnt > THR) begin
        m_tx = 1'b1;
      end
      chk("rnd_rx_en", 32'(rx_enable), 32'(m_run));
      chk("rnd_tx_en", 32'(tx_enable), 32'(m_tx));
      chk("rnd_underrun", 32'(underrun), 32'(m_ur));
      chk("rnd_busy", 32'(busy), 32'd0);
    end

    // Asynchronous reset in the middle of RUN with TX active.
    cmd_enable  = 1'b1;
    tx_empty    = 1'b0;
    tx_rd_count = 12'd300;
    repeat (3) step();
    chk("ar_tx_on", 32'(tx_enable), 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("ar_tx_off", 32'(tx_enable), 32'd0);
    chk("ar_rx_off", 32'(rx_enable), 32'd0);
    chk("ar_fifo_rst", 32'(fifo_rst), 32'd1);
    chk("ar_state", 32'(state), 32'(ST_RESET));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
